// File: rtl/load_store_unit_if.sv
// load_store_unit_if: CPU request/response channel plus data_mem word port
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic        mem_write_en;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_write_en, mem_data_in
  );
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_write_en, mem_data_in
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores onto a word memory, RMW for sub-word stores
module load_store_unit #(
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input logic clk,
  input logic rst_n,
  load_store_unit_if.slave bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] MERGE = 1'b1;
  logic [0:0]  state;
  logic [31:0] cap_addr, cap_mask, cap_rep, shifted, ld;
  logic [1:0]  sz, off;
  logic        store, sext, legal, mis, err, acc, sub;
  // decode, alignment, load extraction and memory-side drive
  always_comb begin
    sz = bus.req_op[1:0];
    store = bus.req_op[3];
    sext = !bus.req_op[2];
    legal = sz != 2'b11 && !(bus.req_op[2] && (bus.req_op[3] || bus.req_op[1]));
    mis = (sz == 2'b01 && bus.req_addr[0]) || (sz == 2'b10 && bus.req_addr[1:0] != 2'b00);
    err = !legal || (MISALIGN_TRAP && mis);
    off = sz == 2'b10 ? 2'b00 : sz == 2'b01 ? {bus.req_addr[1], 1'b0} : bus.req_addr[1:0];
    acc = bus.req_valid && state == IDLE;
    sub = store && sz != 2'b10;
    shifted = bus.mem_data_out >> {off, 3'b000};
    ld = sz == 2'b00 ? {{24{sext && shifted[7]}}, shifted[7:0]} :
         sz == 2'b01 ? {{16{sext && shifted[15]}}, shifted[15:0]} : shifted;
    bus.req_ready = state == IDLE;
    bus.mem_address = state == MERGE ? cap_addr :
                      (rst_n && bus.req_valid) ? {bus.req_addr[31:2], 2'b00} : 32'h0;
    bus.mem_write_en = rst_n && (state == MERGE || (acc && store && !sub && !err));
    bus.mem_data_in = state == MERGE ? (bus.mem_data_out & ~cap_mask) | (cap_rep & cap_mask) :
                      bus.mem_write_en ? bus.req_wdata : 32'h0;
  end
  // state, registered response pulse and sub-word store capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.resp_valid <= 1'b0;
      bus.resp_err <= 1'b0;
      bus.resp_rdata <= 32'h0;
      cap_addr <= 32'h0;
      cap_mask <= 32'h0;
      cap_rep <= 32'h0;
    end else begin
      bus.resp_valid <= state == MERGE || (acc && !(sub && !err));
      bus.resp_err <= acc && err;
      bus.resp_rdata <= (acc && !store && !err) ? ld : 32'h0;
      state <= (acc && sub && !err) ? MERGE : IDLE;
      if (acc) begin
        cap_addr <= {bus.req_addr[31:2], 2'b00};
        cap_mask <= (sz == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << {off, 3'b000};
        cap_rep <= sz == 2'b00 ? {4{bus.req_wdata[7:0]}} : {2{bus.req_wdata[15:0]}};
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of two units (trap on / trap off) against word memories
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b1;
  logic vld = 1'b0;
  logic [3:0] op = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] mem1 [64] = '{default: 32'h0};
  logic [31:0] mem0 [64] = '{default: 32'h0};
  int total = 0;
  int bad = 0;
  load_store_unit_if b1 ();
  load_store_unit_if b0 ();
  load_store_unit #(.MISALIGN_TRAP(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  load_store_unit #(.MISALIGN_TRAP(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  always #5 clk = ~clk;
  assign b1.req_valid = vld && sel;
  assign b0.req_valid = vld && !sel;
  assign b1.req_op = op;
  assign b0.req_op = op;
  assign b1.req_addr = addr;
  assign b0.req_addr = addr;
  assign b1.req_wdata = wdata;
  assign b0.req_wdata = wdata;
  assign b1.mem_data_out = mem1[b1.mem_address[7:2]];
  assign b0.mem_data_out = mem0[b0.mem_address[7:2]];
  always @(posedge clk) begin
    if (b1.mem_write_en) mem1[b1.mem_address[7:2]] <= b1.mem_data_in;
    if (b0.mem_write_en) mem0[b0.mem_address[7:2]] <= b0.mem_data_in;
  end
  wire        rv_m = sel ? b1.resp_valid : b0.resp_valid;
  wire        er_m = sel ? b1.resp_err : b0.resp_err;
  wire [31:0] rd_m = sel ? b1.resp_rdata : b0.resp_rdata;
  wire        we_m = sel ? b1.mem_write_en : b0.mem_write_en;
  wire        rdy_m = sel ? b1.req_ready : b0.req_ready;
  wire [31:0] am_m = sel ? b1.mem_address : b0.mem_address;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic s, input logic [3:0] o, input logic [31:0] a, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd, output logic er, output int wes,
                     output int nrdy, output logic [31:0] am);
    lat = 0;
    rd = 'x;
    er = 1'bx;
    wes = 0;
    nrdy = 0;
    @(negedge clk);
    sel = s;
    op = o;
    addr = a;
    wdata = wd;
    vld = 1'b1;
    #1;
    wes += int'(we_m);
    am = am_m;
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      #1;
      if (rv_m) begin
        lat = c;
        rd = rd_m;
        er = er_m;
      end else begin
        wes += int'(we_m);
        nrdy += int'(!rdy_m);
        @(negedge clk);
      end
    end
  endtask
  initial begin
    int lat, wes, nrdy;
    logic [31:0] rd, am;
    logic er;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(b1.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(b1.resp_valid), 32'd0);
    chk("rst_rdata", b1.resp_rdata, 32'h0);
    chk("rst_err", 32'(b1.resp_err), 32'd0);
    chk("rst_we", 32'(b1.mem_write_en), 32'd0);
    chk("rst_addr", b1.mem_address, 32'h0);
    chk("rst_din", b1.mem_data_in, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b1, 4'b1010, 32'h10, 32'hDEADBEEF, lat, rd, er, wes, nrdy, am);
    chk("sw_lat", lat, 1);
    chk("sw_we", wes, 1);
    chk("sw_err", 32'(er), 32'd0);
    chk("sw_mem", mem1[4], 32'hDEADBEEF);
    run(1'b1, 4'b0010, 32'h10, 32'h0, lat, rd, er, wes, nrdy, am);
    chk("lw_lat", lat, 1);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_err", 32'(er), 32'd0);
    run(1'b1, 4'b1000, 32'h12, 32'h55, lat, rd, er, wes, nrdy, am);
    chk("sb_lat", lat, 2);
    chk("sb_we", wes, 1);
    chk("sb_notready", nrdy, 1);
    chk("sb_rdata", rd, 32'h0);
    run(1'b1, 4'b0010, 32'h10, 32'h0, lat, rd, er, wes, nrdy, am);
    chk("lw_after_sb", rd, 32'hDE55BEEF);
    run(1'b1, 4'b0000, 32'h13, 32'h0, lat, rd, er, wes, nrdy, am);
    chk("lb_13", rd, 32'hFFFFFFDE);
    run(1'b1, 4'b0100, 32'h13, 32'h0, lat, rd, er, wes, nrdy, am);
    chk("lbu_13", rd, 32'h000000DE);
    run(1'b1, 4'b0001, 32'h12, 32'h0, lat, rd, er, wes, nrdy, am);
    chk("lh_12", rd, 32'hFFFFDE55);
    run(1'b1, 4'b0101, 32'h10, 32'h0, lat, rd, er, wes, nrdy, am);
    chk("lhu_10", rd, 32'h0000BEEF);
    run(1'b1, 4'b0010, 32'h11, 32'h0, lat, rd, er, wes, nrdy, am);
    chk("lw_mis_err", 32'(er), 32'd1);
    chk("lw_mis_rdata", rd, 32'h0);
    chk("lw_mis_we", wes, 0);
    run(1'b1, 4'b1001, 32'h13, 32'hFFFF, lat, rd, er, wes, nrdy, am);
    chk("sh_mis_err", 32'(er), 32'd1);
    chk("sh_mis_lat", lat, 1);
    chk("sh_mis_we", wes, 0);
    run(1'b1, 4'b1111, 32'h10, 32'hFFFFFFFF, lat, rd, er, wes, nrdy, am);
    chk("illegal_err", 32'(er), 32'd1);
    chk("illegal_rdata", rd, 32'h0);
    chk("illegal_we", wes, 0);
    chk("trap_mem_kept", mem1[4], 32'hDE55BEEF);
    run(1'b0, 4'b1010, 32'h13, 32'h01020304, lat, rd, er, wes, nrdy, am);
    chk("sw_force_addr", am, 32'h10);
    chk("sw_force_err", 32'(er), 32'd0);
    chk("sw_force_we", wes, 1);
    chk("sw_force_mem", mem0[4], 32'h01020304);
    run(1'b0, 4'b0010, 32'h10, 32'h0, lat, rd, er, wes, nrdy, am);
    chk("lw_force", rd, 32'h01020304);
    run(1'b0, 4'b1001, 32'h13, 32'h0000AAAA, lat, rd, er, wes, nrdy, am);
    chk("sh_force_lat", lat, 2);
    chk("sh_force_err", 32'(er), 32'd0);
    run(1'b0, 4'b0010, 32'h10, 32'h0, lat, rd, er, wes, nrdy, am);
    chk("lw_after_sh_force", rd, 32'hAAAA0304);
    @(negedge clk);
    sel = 1'b1;
    op = 4'b1001;
    addr = 32'h20;
    wdata = 32'h1234;
    vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
    #1;
    chk("merge_we", 32'(b1.mem_write_en), 32'd1);
    chk("merge_notready", 32'(b1.req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_merge_we", 32'(b1.mem_write_en), 32'd0);
    chk("rst_merge_ready", 32'(b1.req_ready), 32'd1);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_merge_no_resp", 32'(b1.resp_valid), 32'd0);
    chk("rst_merge_mem", mem1[8], 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_ready", 32'(b1.req_ready), 32'd1);
    chk("post_rst_no_resp", 32'(b1.resp_valid), 32'd0);
    run(1'b1, 4'b0010, 32'h20, 32'h0, lat, rd, er, wes, nrdy, am);
    chk("post_rst_lw20", rd, 32'h0);
    run(1'b1, 4'b0010, 32'h10, 32'h0, lat, rd, er, wes, nrdy, am);
    chk("post_rst_lw10", rd, 32'hDE55BEEF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
